// File: rtl/sram_ctrl.sv
// SRAM controller: splits one 32-bit CPU access into two 16-bit SRAM transfers
// (low half then high half), then idles WAIT_CYCLES cycles before completing.
module sram_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in
);

  typedef enum logic [2:0] {StIdle, StLo, StHi, StWait, StDone} state_t;

  // Last count value spent in WAIT before moving on to DONE.
  localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        op_wr_q;
  logic [16:0] word_q;
  logic [31:0] wdata_q;
  logic [31:0] read_data_q;
  logic        req;

  assign req       = rd_en | wr_en;
  assign read_data = read_data_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests are only sampled in IDLE, so DONE ignores them.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req) state_d = StLo;
      StLo:   state_d = StHi;
      StHi:   state_d = StWait;
      StWait: if (cnt_q == WaitLast) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Wait counter: cleared leaving HI, advanced while in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 4'd0;
    end else if (state_q == StHi) begin
      cnt_q <= 4'd0;
    end else if (state_q == StWait) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // Latch operation, word offset and store data when leaving IDLE so a request
  // dropped mid-access does not disturb it. Write wins over read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr_q <= 1'b0;
      word_q  <= 17'd0;
      wdata_q <= 32'd0;
    end else if (state_q == StIdle && req) begin
      op_wr_q <= wr_en;
      word_q  <= 17'((address - BASE_ADDR) >> 2);
      wdata_q <= write_data;
    end
  end

  // Read data capture: low half at end of LO, high half at end of HI.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data_q <= 32'd0;
    end else if (!op_wr_q) begin
      if (state_q == StLo) read_data_q[15:0]  <= sram_dq_in;
      if (state_q == StHi) read_data_q[31:16] <= sram_dq_in;
    end
  end

  // SRAM pins and ready decoded from the current state.
  always_comb begin
    sram_addr   = 18'd0;
    sram_we_n   = 1'b1;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    ready       = 1'b0;
    unique case (state_q)
      StIdle: ready = ~req;
      StLo: begin
        sram_addr = {word_q, 1'b0};
        if (op_wr_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[15:0];
        end
      end
      StHi: begin
        sram_addr = {word_q, 1'b1};
        if (op_wr_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[31:16];
        end
      end
      StWait: ready = 1'b0;
      StDone: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a small behavioural SRAM.
module tb_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:15];

  // Per-cycle record of one access, index 0 = request cycle.
  logic [17:0] rec_addr [0:19];
  logic        rec_wen  [0:19];
  logic        rec_oe   [0:19];
  logic [15:0] rec_dq   [0:19];
  int          low_cnt;
  int          wen_low;

  sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_we_n  (sram_we_n),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read SRAM, write on rising edge while strobe low.
  assign sram_dq_in = mem[sram_addr[3:0]];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[3:0]] <= sram_dq_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  // Drive a request and record pins every cycle until ready rises (DONE).
  // Leaves the request asserted; returns at the DONE sample point.
  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d);
    int n;
    wr_en = wr;
    rd_en = rd;
    address = a;
    write_data = d;
    #1;
    n = 0;
    wen_low = 0;
    forever begin
      rec_addr[n] = sram_addr;
      rec_wen[n]  = sram_we_n;
      rec_oe[n]   = sram_dq_oe;
      rec_dq[n]   = sram_dq_out;
      if (!sram_we_n) wen_low++;
      if (ready) break;
      n++;
      if (n >= 19) begin
        chk("ready_timeout", 32'd1, 32'd0);
        break;
      end
      next_cyc();
    end
    low_cnt = n;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[4] = 16'hCAFE;
    mem[5] = 16'h0BAD;
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    address = 32'd0;
    write_data = 32'd0;
    next_cyc();
    next_cyc();

    // Reset state.
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    rst = 1'b1;
    next_cyc();

    // Write 0xDEADBEEF to 1024.
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    chk("wr1_low_cycles", 32'(low_cnt), 32'd6);
    chk("wr1_lo_addr", 32'(rec_addr[1]), 32'd0);
    chk("wr1_lo_dq", 32'(rec_dq[1]), 32'hBEEF);
    chk("wr1_lo_we_n", 32'(rec_wen[1]), 32'd0);
    chk("wr1_lo_oe", 32'(rec_oe[1]), 32'd1);
    chk("wr1_hi_addr", 32'(rec_addr[2]), 32'd1);
    chk("wr1_hi_dq", 32'(rec_dq[2]), 32'hDEAD);
    chk("wr1_hi_we_n", 32'(rec_wen[2]), 32'd0);
    chk("wr1_wait_we_n", 32'(rec_wen[3]), 32'd1);
    chk("wr1_wait_oe", 32'(rec_oe[4]), 32'd0);
    chk("wr1_wait_dq", 32'(rec_dq[5]), 32'd0);
    chk("wr1_req_we_n", 32'(rec_wen[0]), 32'd1);
    chk("wr1_we_low_count", 32'(wen_low), 32'd2);
    wr_en = 1'b0;
    next_cyc();
    chk("idle_ready", 32'(ready), 32'd1);

    // Read it back.
    access(1'b0, 1'b1, 32'd1024, 32'd0);
    chk("rd1_low_cycles", 32'(low_cnt), 32'd6);
    chk("rd1_data", read_data, 32'hDEADBEEF);
    chk("rd1_we_low_count", 32'(wen_low), 32'd0);
    chk("rd1_oe_lo", 32'(rec_oe[1]), 32'd0);
    rd_en = 1'b0;
    next_cyc();

    // Read 1032 (W=2), then a write to 1036 must not touch read_data.
    access(1'b0, 1'b1, 32'd1032, 32'd0);
    chk("rd2_lo_addr", 32'(rec_addr[1]), 32'd4);
    chk("rd2_hi_addr", 32'(rec_addr[2]), 32'd5);
    chk("rd2_data", read_data, 32'h0BADCAFE);
    rd_en = 1'b0;
    next_cyc();
    access(1'b1, 1'b0, 32'd1036, 32'h11112222);
    chk("wr2_lo_addr", 32'(rec_addr[1]), 32'd6);
    chk("wr2_hi_addr", 32'(rec_addr[2]), 32'd7);
    chk("wr2_keeps_read_data", read_data, 32'h0BADCAFE);
    wr_en = 1'b0;
    next_cyc();

    // Read and write both requested: write wins.
    access(1'b1, 1'b1, 32'd1040, 32'h12345678);
    chk("both_low_cycles", 32'(low_cnt), 32'd6);
    chk("both_we_low_count", 32'(wen_low), 32'd2);
    chk("both_lo_we_n", 32'(rec_wen[1]), 32'd0);
    chk("both_hi_we_n", 32'(rec_wen[2]), 32'd0);
    chk("both_read_data", read_data, 32'h0BADCAFE);
    chk("both_mem_lo", 32'(mem[8]), 32'h5678);
    chk("both_mem_hi", 32'(mem[9]), 32'h1234);
    wr_en = 1'b0;
    rd_en = 1'b0;
    next_cyc();

    // Reset during HI of a write.
    wr_en = 1'b1;
    address = 32'd1044;
    write_data = 32'hAAAA5555;
    next_cyc();
    next_cyc();
    chk("rstmid_hi_we_n_before", 32'(sram_we_n), 32'd0);
    rst = 1'b0;
    #1;
    chk("rstmid_we_n", 32'(sram_we_n), 32'd1);
    chk("rstmid_oe", 32'(sram_dq_oe), 32'd0);
    chk("rstmid_addr", 32'(sram_addr), 32'd0);
    chk("rstmid_read_data", read_data, 32'd0);
    wr_en = 1'b0;
    next_cyc();
    rst = 1'b1;
    next_cyc();
    chk("rstmid_ready_after", 32'(ready), 32'd1);
    // Only the LO half of the aborted write reached the SRAM.
    access(1'b0, 1'b1, 32'd1044, 32'd0);
    chk("rstmid_rd_low_cycles", 32'(low_cnt), 32'd6);
    chk("rstmid_rd_data", read_data, 32'h00005555);
    rd_en = 1'b0;
    next_cyc();

    // Back-to-back reads with the request held through DONE.
    access(1'b0, 1'b1, 32'd1024, 32'd0);
    chk("b2b_first_low", 32'(low_cnt), 32'd6);
    chk("b2b_first_data", read_data, 32'hDEADBEEF);
    next_cyc();
    access(1'b0, 1'b1, 32'd1032, 32'd0);
    chk("b2b_second_low", 32'(low_cnt), 32'd6);
    chk("b2b_second_idle_addr", 32'(rec_addr[0]), 32'd0);
    chk("b2b_second_lo_addr", 32'(rec_addr[1]), 32'd4);
    chk("b2b_second_hi_addr", 32'(rec_addr[2]), 32'd5);
    chk("b2b_second_data", read_data, 32'h0BADCAFE);
    rd_en = 1'b0;
    next_cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'd1024: CPU byte address that maps to SRAM word 0.
REQ-002 Parameter WAIT_CYCLES, default 3: idle settle cycles after the two half-word transfers; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  write request from the MEM stage; held stable while ready=0.
REQ-006 rd_en  input  1  read request from the MEM stage; held stable while ready=0.
REQ-007 address  input  32  CPU byte address; word-aligned.
REQ-008 write_data  input  32  store data.
REQ-009 read_data  output  32  load data; registered.
REQ-010 ready  output  1  1 = no access pending or access completing; the pipeline freezes on ready=0.
REQ-011 sram_addr  output  18  SRAM half-word address.
REQ-012 sram_we_n  output  1  SRAM write strobe, active-low.
REQ-013 sram_dq_out  output  16  SRAM write data.
REQ-014 sram_dq_oe  output  1  1 = controller drives the SRAM data bus.
REQ-015 sram_dq_in  input  16  SRAM read data; valid in the same cycle sram_addr is presented.

Function
REQ-016 The FSM SHALL have states IDLE, LO, HI, WAIT and DONE.
- IDLE -> LO when rd_en|wr_en.
- LO -> HI.
- HI -> WAIT.
- WAIT -> DONE after WAIT_CYCLES cycles in WAIT, counted by a 4-bit counter cleared on HI exit.
- DONE -> IDLE unconditionally.
REQ-017 The controller SHALL latch the operation on IDLE exit; wr_en takes priority when rd_en and wr_en are both 1.
REQ-018 The controller SHALL compute word offset W = (address - BASE_ADDR) >> 2, taking bits [16:0] and discarding overflow.
- In LO: sram_addr = {W,1'b0}.
- In HI: sram_addr = {W,1'b1}.
- In all other states: sram_addr = 0.
REQ-019 During a write, LO SHALL drive sram_we_n=0, sram_dq_oe=1, sram_dq_out=write_data[15:0]; HI SHALL drive the same with write_data[31:16].
REQ-020 In every other state, and for reads, outputs SHALL be sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
REQ-021 During a read, read_data[15:0] SHALL capture sram_dq_in at the end of LO and read_data[31:16] at the end of HI.
- read_data SHALL hold its value until the next read.
- read_data SHALL be unchanged by writes.
REQ-022 ready SHALL be combinational:
- 1 in IDLE with rd_en=wr_en=0.
- 0 in IDLE with a request.
- 0 in LO, HI and WAIT.
- 1 in DONE.
REQ-023 With WAIT_CYCLES=3, ready SHALL be 0 for exactly 6 consecutive cycles from the request cycle and 1 in the 7th; generally 3+WAIT_CYCLES low cycles.
REQ-024 Requests present in DONE SHALL be ignored; they are re-evaluated in the following IDLE cycle, so back-to-back accesses incur one ready=1 cycle between them.
REQ-025 Deassertion of rd_en/wr_en after IDLE exit SHALL NOT abort the access.

Reset
REQ-026 While rst=0, asynchronously:
- state=IDLE, wait counter=0, latched operation=read.
- read_data=0, sram_addr=0, sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
REQ-027 Reset asserted mid-access SHALL abandon the access immediately with sram_we_n=1 and no partial read_data update on that edge.
REQ-028 After rst rises, the first rising edge SHALL evaluate requests from IDLE.

Verification
REQ-029 Write 0xDEADBEEF to address 1024 -> LO: sram_addr=0, dq_out=0xBEEF, we_n=0; HI: sram_addr=1, dq_out=0xDEAD, we_n=0; ready low for 6 cycles.
REQ-030 After REQ-029, read address 1024 with an SRAM model -> read_data=0xDEADBEEF in the DONE cycle; ready=1 in cycle 7.
REQ-031 Read address 1032 (W=2) -> sram_addr 4 then 5; a write to address 1036 afterwards leaves read_data unchanged.
REQ-032 rd_en=wr_en=1 with write_data=0x12345678 -> write performed; read_data unchanged; we_n low only in LO and HI.
REQ-033 rst=0 during HI of a write -> same cycle: we_n=1, oe=0, sram_addr=0; after release with no request, ready=1.
REQ-034 Two back-to-back reads held continuously -> ready pattern 0x6,1,0x6,1; second sram_addr sequence starts on the cycle after DONE.
